// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm-game lane logic.
// State/grade enums, keycodes and the 40x40 arrow bitmap builder.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_WAIT,
    ST_FALL,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    G_MISS    = 2'd0,
    G_GOOD    = 2'd1,
    G_PERFECT = 2'd2
  } grade_t;

  localparam logic [7:0] KEY_START   = 8'h2c;
  localparam logic [7:0] KEY_RESTART = 8'h01;

  localparam int SPR_W    = 40;
  localparam int SPR_H    = 40;
  localparam int SPR_BITS = SPR_W * SPR_H;

  // Up arrow: triangular head in rows 0..19, shaft cols 14..25 below.
  function automatic logic up_px(int r, int c);
    int d;
    d = (c < 20) ? (19 - c) : (c - 20);
    if (r < 20)
      return (d <= r);
    return (c >= 14) && (c <= 25);
  endfunction

  // Rotate the up arrow clockwise by dir quarter turns.
  function automatic logic [SPR_BITS-1:0] arrow_bitmap(int dir);
    logic [SPR_BITS-1:0] bm;
    bm = '0;
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        case (dir)
          1:       bm[r*SPR_W+c] = up_px(39 - c, r);
          2:       bm[r*SPR_W+c] = up_px(39 - r, c);
          3:       bm[r*SPR_W+c] = up_px(c, r);
          default: bm[r*SPR_W+c] = up_px(r, c);
        endcase
      end
    end
    return bm;
  endfunction

endpackage

// File: rtl/arrow_sprite_rom.sv
// Constant 40x40 arrow bitmap, bit index = row*40+col.
// DIR picks orientation: 0=up, 1=right, 2=down, 3=left.
module arrow_sprite_rom
  import rhythm_pkg::*;
#(
  parameter int DIR = 0
) (
  output logic [SPR_BITS-1:0] bitmap
);

  localparam logic [SPR_BITS-1:0] BITMAP =
    arrow_bitmap(DIR);

  assign bitmap = BITMAP;

endmodule

// File: rtl/note_lane_dropper.sv
// One falling note lane: arm, delay, fall, judge hit or miss.
// Optional DROPPER_PERFECT_GRADE_EN adds perfect grading near window centre.
module note_lane_dropper
  import rhythm_pkg::*;
#(
  parameter int         X_START     = 100,
  parameter int         Y_START     = 100,
  parameter int         Y_MAX       = 400,
  parameter int         HIT_LO      = 340,
  parameter int         HIT_HI      = 400,
  parameter int         SPRITE_H    = 40,
  parameter int         START_DELAY = 1820,
  parameter int         SPEED       = 1,
  parameter logic [7:0] LANE_KEY    = 8'h1a,
  parameter int         DIR         = 0
`ifdef DROPPER_PERFECT_GRADE_EN
  ,
  parameter int         PERFECT_TOL = 8
`endif
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          keycode,
  input  logic [7:0]          keycode_second,
  output logic [9:0]          dropX,
  output logic [9:0]          dropY,
  output logic [SPR_BITS-1:0] arrow,
  output logic                visible,
  output logic                score,
  output logic                hit_pulse,
  output logic                miss_pulse,
  output logic [1:0]          grade
);

  localparam logic [10:0] Y0    = 11'(Y_START);
  localparam logic [10:0] H     = 11'(SPRITE_H);
  localparam logic [10:0] YMAX  = 11'(Y_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX - SPRITE_H);
  localparam logic [10:0] LO    = 11'(HIT_LO);
  localparam logic [10:0] HI    = 11'(HIT_HI);
  localparam logic [10:0] STEP  = 11'(SPEED);
  localparam logic [11:0] DLY   = 12'(START_DELAY);

  state_t      state;
  state_t      state_nxt;
  logic [11:0] counter;
  logic [10:0] drop_y;
  logic        prev_key;
  grade_t      grade_q;

  logic [SPR_BITS-1:0] rom_bits;

  logic        key_now;
  logic        press;
  logic        start_key;
  logic        restart_key;
  logic [10:0] lower;
  logic [10:0] moved;
  logic [10:0] moved_clamp;
  logic        at_bottom;
  logic        in_window;
  logic        fall_hit;
  grade_t      hit_grade;

  arrow_sprite_rom #(
    .DIR(DIR)
  ) u_rom (
    .bitmap(rom_bits)
  );

  assign key_now = (keycode == LANE_KEY) ||
                   (keycode_second == LANE_KEY);
  assign press   = key_now && !prev_key;

  assign start_key   = (keycode == KEY_START) ||
                       (keycode_second == KEY_START);
  assign restart_key = (keycode == KEY_RESTART) ||
                       (keycode_second == KEY_RESTART);

  assign lower       = drop_y + H;
  assign moved       = drop_y + STEP;
  assign moved_clamp = (moved > Y_LIM) ? Y_LIM : moved;
  assign at_bottom   = (lower >= YMAX);
  assign in_window   = (lower >= LO) && (lower < HI);
  assign fall_hit    = !at_bottom && press && in_window;

`ifdef DROPPER_PERFECT_GRADE_EN
  localparam logic [10:0] MID = 11'((HIT_LO + HIT_HI) / 2);
  localparam logic [10:0] TOL = 11'(PERFECT_TOL);
  logic [10:0] dist;
  assign dist = (lower >= MID) ? (lower - MID) : (MID - lower);
  assign hit_grade = (dist <= TOL) ? G_PERFECT : G_GOOD;
`else
  assign hit_grade = G_GOOD;
`endif

  // State register.
  always_ff @(posedge frame_clk) begin
    if (Reset) state <= ST_HALTED;
    else       state <= state_nxt;
  end

  // Next-state decode; bottom miss outranks a same-frame press.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_HALTED: if (start_key) state_nxt = ST_WAIT;
      ST_WAIT:   if (counter == DLY) state_nxt = ST_FALL;
      ST_FALL:   if (at_bottom || fall_hit) state_nxt = ST_DONE;
      ST_DONE:   if (restart_key) state_nxt = ST_HALTED;
      default:   state_nxt = ST_HALTED;
    endcase
  end

  // Datapath: delay counter, sprite motion, judgement and key edge.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      counter    <= '0;
      drop_y     <= Y0;
      score      <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      grade_q    <= G_MISS;
      prev_key   <= 1'b0;
    end else begin
      prev_key   <= key_now;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      unique case (state)
        ST_HALTED: begin
          if (start_key) begin
            counter <= '0;
            drop_y  <= Y0;
            score   <= 1'b0;
            grade_q <= G_MISS;
          end
        end
        ST_WAIT: counter <= counter + 12'd1;
        ST_FALL: begin
          if (at_bottom) begin
            miss_pulse <= 1'b1;
            grade_q    <= G_MISS;
          end else if (fall_hit) begin
            hit_pulse <= 1'b1;
            score     <= 1'b1;
            grade_q   <= hit_grade;
          end else begin
            drop_y <= moved_clamp;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs derived from state and datapath registers.
  always_comb begin
    visible = (state == ST_WAIT) || (state == ST_FALL);
    arrow   = visible ? rom_bits : '0;
    dropX   = 10'(X_START);
    dropY   = drop_y[9:0];
    grade   = grade_q;
  end

endmodule

// File: tb/tb_note_lane_dropper.sv
// Scoreboard bench for note_lane_dropper (default and SPEED=7 lanes).
// Expected hit/miss events are queued at stimulus time, popped on pulses.
module tb_note_lane_dropper;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic [7:0]  keycode_second = 8'h00;

  logic [9:0]    dropX, dropY;
  logic [1599:0] arrow;
  logic          visible, score, hit_pulse, miss_pulse;
  logic [1:0]    grade;

  logic [9:0]    dropX7, dropY7;
  logic [1599:0] arrow7;
  logic          visible7, score7, hit7, miss7;
  logic [1:0]    grade7;

  typedef struct {
    logic       hit;
    logic [1:0] grade;
    logic [9:0] y;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef DROPPER_PERFECT_GRADE_EN
  localparam logic [1:0] G_CENTRE = 2'd2;
`else
  localparam logic [1:0] G_CENTRE = 2'd1;
`endif

  note_lane_dropper #(
    .START_DELAY(4)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode_second(keycode_second),
    .dropX(dropX), .dropY(dropY), .arrow(arrow),
    .visible(visible), .score(score),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .grade(grade)
  );

  note_lane_dropper #(
    .START_DELAY(4), .SPEED(7)
  ) dut7 (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode(keycode), .keycode_second(keycode_second),
    .dropX(dropX7), .dropY(dropY7), .arrow(arrow7),
    .visible(visible7), .score(score7),
    .hit_pulse(hit7), .miss_pulse(miss7),
    .grade(grade7)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    keycode = 8'h00;
    keycode_second = 8'h00;
    step(2);
    Reset = 1'b0;
    step(1);
  endtask

  task automatic arm();
    keycode = 8'h2c;
    step(1);
    keycode = 8'h00;
  endtask

  task automatic wait_event(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (hit_pulse || miss_pulse) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_y(input logic [9:0] y, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (dropY == y) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic restart();
    keycode = 8'h01;
    step(1);
    keycode = 8'h00;
    step(1);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    do_reset();
    got = {visible, score, hit_pulse, miss_pulse,
           grade, dropY};
    n_checks++;
    if (got !== {4'b0000, 2'd0, 10'd100}) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h",
               got, {4'b0000, 2'd0, 10'd100});
    end
    n_checks++;
    if (dropX !== 10'd100) begin
      n_errors++;
      $display("FAIL reset_dropx: got %0d expected 100", dropX);
    end
    n_checks++;
    if (arrow !== '0) begin
      n_errors++;
      $display("FAIL reset_arrow: got nonzero expected zero");
    end
  endtask

  task automatic test_miss();
    bit   ok;
    exp_t e;
    logic [15:0] got, want;
    do_reset();
    arm();
    n_checks++;
    if ({visible, dropY} !== {1'b1, 10'd100}) begin
      n_errors++;
      $display("FAIL arm_visible: got %b/%0d expected 1/100",
               visible, dropY);
    end
    n_checks++;
    if ({arrow[19], arrow[0], arrow[1580], arrow[1560]}
        !== 4'b1010) begin
      n_errors++;
      $display("FAIL arrow_bits: got %b expected 1010",
               {arrow[19], arrow[0], arrow[1580], arrow[1560]});
    end
    step(5);
    n_checks++;
    if ({visible, dropY} !== {1'b1, 10'd100}) begin
      n_errors++;
      $display("FAIL wait_hold: got %b/%0d expected 1/100",
               visible, dropY);
    end
    step(1);
    n_checks++;
    if (dropY !== 10'd101) begin
      n_errors++;
      $display("FAIL first_move: got %0d expected 101", dropY);
    end
    sb_q.push_back('{hit: 1'b0, grade: 2'd0, y: 10'd360});
    wait_event(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL miss_timeout: got none expected miss");
    end else begin
      e = sb_q.pop_front();
      got  = {hit_pulse, miss_pulse, grade, dropY, score, visible};
      want = {e.hit, !e.hit, e.grade, e.y, e.hit, 1'b0};
      if (got !== want) begin
        n_errors++;
        $display("FAIL miss_event: got %h expected %h", got, want);
      end
    end
    keycode = 8'h2c;
    step(1);
    n_checks++;
    if ({hit_pulse, miss_pulse, visible, dropY}
        !== {3'b000, 10'd360}) begin
      n_errors++;
      $display("FAIL done_hold: got %b%b%b/%0d expected 000/360",
               hit_pulse, miss_pulse, visible, dropY);
    end
    keycode = 8'h01;
    step(1);
    keycode = 8'h2c;
    step(1);
    keycode = 8'h00;
    n_checks++;
    if ({visible, dropY, score} !== {1'b1, 10'd100, 1'b0}) begin
      n_errors++;
      $display("FAIL rearm: got %b/%0d/%b expected 1/100/0",
               visible, dropY, score);
    end
  endtask

  task automatic test_hit(input logic [9:0] edge_y,
                          input logic [1:0] g);
    bit   ok;
    exp_t e;
    logic [14:0] got, want;
    do_reset();
    arm();
    wait_y(edge_y - 10'd40, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL hit_reach: got %0d expected %0d",
               dropY, edge_y - 10'd40);
    end
    sb_q.push_back('{hit: 1'b1, grade: g, y: edge_y - 10'd40});
    keycode = 8'h1a;
    step(1);
    keycode = 8'h00;
    wait_event(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL hit_timeout: got none expected hit");
    end else begin
      e = sb_q.pop_front();
      got  = {hit_pulse, miss_pulse, grade, dropY, score};
      want = {e.hit, !e.hit, e.grade, e.y, e.hit};
      if (got !== want) begin
        n_errors++;
        $display("FAIL hit_event_%0d: got %h expected %h",
                 edge_y, got, want);
      end
    end
    step(2);
    n_checks++;
    if ({hit_pulse, score, grade, dropY}
        !== {2'b01, g, edge_y - 10'd40}) begin
      n_errors++;
      $display("FAIL hit_hold_%0d: got %b%b/%0d/%0d",
               edge_y, hit_pulse, score, grade, dropY);
    end
    restart();
  endtask

  task automatic test_held_key();
    bit   ok;
    exp_t e;
    logic [14:0] got, want;
    do_reset();
    keycode = 8'h2c;
    keycode_second = 8'h1a;
    step(1);
    keycode = 8'h00;
    sb_q.push_back('{hit: 1'b0, grade: 2'd0, y: 10'd360});
    wait_event(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL held_timeout: got none expected miss");
    end else begin
      e = sb_q.pop_front();
      got  = {hit_pulse, miss_pulse, grade, dropY, score};
      want = {e.hit, !e.hit, e.grade, e.y, e.hit};
      if (got !== want) begin
        n_errors++;
        $display("FAIL held_event: got %h expected %h", got, want);
      end
    end
    keycode_second = 8'h00;
    restart();
  endtask

  task automatic test_reset_mid_fall();
    bit ok;
    bit pulsed;
    do_reset();
    arm();
    wait_y(10'd250, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rst_reach: got %0d expected 250", dropY);
    end
    Reset = 1'b1;
    step(1);
    n_checks++;
    if ({visible, hit_pulse, miss_pulse, dropY}
        !== {3'b000, 10'd100}) begin
      n_errors++;
      $display("FAIL rst_mid_fall: got %b%b%b/%0d expected 000/100",
               visible, hit_pulse, miss_pulse, dropY);
    end
    Reset = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (hit_pulse || miss_pulse || visible) pulsed = 1'b1;
    end
    n_checks++;
    if (pulsed !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_quiet: got activity expected none");
    end
    arm();
    n_checks++;
    if (visible !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_rearm: got %b expected 1", visible);
    end
  endtask

  task automatic test_speed7();
    int   misses;
    int   max_y;
    bit   popped;
    exp_t e;
    logic [14:0] got, want;
    do_reset();
    arm();
    sb_q.push_back('{hit: 1'b0, grade: 2'd0, y: 10'd360});
    misses = 0;
    max_y  = 0;
    popped = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (int'(dropY7) > max_y) max_y = int'(dropY7);
      if (miss7) begin
        misses++;
        if (!popped) begin
          popped = 1'b1;
          e = sb_q.pop_front();
          got  = {hit7, miss7, grade7, dropY7, score7};
          want = {e.hit, !e.hit, e.grade, e.y, e.hit};
          n_checks++;
          if (got !== want) begin
            n_errors++;
            $display("FAIL spd7_event: got %h expected %h",
                     got, want);
          end
        end
      end
      step(1);
    end
    n_checks++;
    if (!popped) begin
      n_errors++;
      $display("FAIL spd7_timeout: got none expected miss");
      void'(sb_q.pop_front());
    end
    n_checks++;
    if (max_y != 360) begin
      n_errors++;
      $display("FAIL spd7_max_y: got %0d expected 360", max_y);
    end
    n_checks++;
    if (misses != 1) begin
      n_errors++;
      $display("FAIL spd7_miss_count: got %0d expected 1", misses);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit(10'd360, 2'd1);
    test_hit(10'd370, G_CENTRE);
    test_hit(10'd342, 2'd1);
    test_held_key();
    test_reset_mid_fall();
    test_speed7();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_lane_dropper.md
NOTE_LANE_DROPPER -- requirements
Module: note_lane_dropper

Interface
REQ-001 SHALL have parameter X_START, default 100: fixed sprite X.
REQ-002 SHALL have parameter Y_START, default 100: sprite Y on arm.
REQ-003 SHALL have parameter Y_MAX, default 400: bottom limit for the sprite's lower edge.
REQ-004 SHALL have parameter HIT_LO / HIT_HI, default 340 / 400: hit window on the lower edge, lower-inclusive, upper-exclusive.
REQ-005 SHALL have parameter SPRITE_H, default 40: sprite height in pixels.
REQ-006 SHALL have parameter START_DELAY, default 1820: frames from arm to fall; range 0..4095.
REQ-007 SHALL have parameter SPEED, default 1: pixels per frame; range 1..15.
REQ-008 SHALL have parameter LANE_KEY, default 8'h1a: hit keycode.
REQ-009 SHALL have parameter DIR, default 0: arrow orientation, 0=up, 1=right, 2=down, 3=left.
REQ-010 SHALL have ports, in this order:
- frame_clk  in  1  clock
- Reset  in  1  reset: synchronous, active-high
- keycode, keycode_second  in  8 each  USB key slots
- dropX, dropY  out  10 each  sprite origin
- arrow  out  1600  40x40 bitmap, bit = row*40+col
- visible  out  1  sprite drawn
- score  out  1  level, latched hit
- hit_pulse, miss_pulse  out  1 each  one-frame event
- grade  out  2  0=miss, 1=good, 2=perfect

Function
REQ-011 SHALL implement a state machine with states HALTED, WAIT, FALL and DONE.
REQ-012 HALTED: when either key slot equals 8'h2c, SHALL go to WAIT next frame, with counter=0, dropY=Y_START and score=0.
REQ-013 WAIT: SHALL increment the counter each frame; when counter==START_DELAY, SHALL go to FALL; START_DELAY=0 SHALL reach FALL one frame after arm.
REQ-014 FALL, per frame, in priority order: (a) lower edge dropY+SPRITE_H>=Y_MAX -> DONE with miss; (b) key press while HIT_LO<=lower edge<HIT_HI -> DONE with hit; (c) otherwise dropY+=SPEED.
REQ-015 Key press SHALL mean LANE_KEY is present in either slot this frame and was absent in both slots the previous frame; a key held across the window entry SHALL NOT count as a hit.
REQ-016 Miss and press in the same frame SHALL resolve to miss.
REQ-017 Arithmetic SHALL use 11 bits so that dropY+SPRITE_H and dropY+SPEED do not wrap; dropY SHALL be clamped so it never exceeds Y_MAX-SPRITE_H.
REQ-018 On entering DONE, SHALL assert hit_pulse or miss_pulse for exactly one frame; on hit, score SHALL go to 1 and hold until HALTED.
REQ-019 DONE: when either key slot equals 8'h01, SHALL go to HALTED; all other keys SHALL be ignored.
REQ-020 visible SHALL be 1 in WAIT and FALL, and 0 in HALTED and DONE; arrow SHALL be all-zero when visible=0.
REQ-021 dropX SHALL always equal X_START.

Reset
REQ-022 Reset SHALL force: state=HALTED, counter=0, dropY=Y_START, score=0, pulses=0, grade=0, previous-key flag=0.
REQ-023 Reset asserted mid-FALL SHALL take effect next edge, with no pulse emitted.

Configuration
REQ-024 Macro DROPPER_PERFECT_GRADE_EN defined: a hit SHALL give grade=2 when |lower edge-(HIT_LO+HIT_HI)/2|<=PERFECT_TOL (parameter, default 8), else grade=1.
REQ-025 Macro absent: every hit SHALL give grade=1, grade=2 SHALL never occur, and PERFECT_TOL SHALL be unused.
REQ-026 In both modes, grade SHALL be valid from DONE entry until HALTED, and a miss SHALL give grade=0.

Structure
REQ-027 Package rhythm_pkg SHALL hold: the state enum, the grade enum, keycode constants (KEY_START 8'h2c, KEY_RESTART 8'h01) and sprite constants (40x40, 1600 bits).
REQ-028 Sub-module arrow_sprite_rom, parameter DIR, SHALL output the constant 1600-bit arrow bitmap, rotated per DIR.

Verification
REQ-029 Arm at frame 0, START_DELAY=4, no key -> visible at frame 1; first move at frame 6; miss_pulse when lower edge reaches 400; grade=0; score=0.
REQ-030 Key 8'h1a pressed when lower edge=360 -> hit_pulse once; score=1; dropY frozen at 320.
REQ-031 8'h1a held from frame 0 through the window -> miss (edge rule).
REQ-032 With the macro: press at lower edge=370 -> grade=2; press at 342 -> grade=1; without the macro, both -> grade=1.
REQ-033 Reset mid-FALL at dropY=250 -> next frame HALTED, dropY=100, no pulse; then 8'h01 in DONE -> HALTED, and 8'h2c re-arms.
REQ-034 SPEED=7 -> dropY never exceeds 360, and miss fires exactly once.
